// File: rtl/fft_cooley_tukey_helpers_stage_sequencer_pkg.sv
// fft_cooley_tukey_helpers_SequencerPkg: shared state encoding, stage width helper and perf counter width
package fft_cooley_tukey_helpers_SequencerPkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} seq_state_t;
  localparam int PERF_W = 16;
  function automatic int stage_width(input int size_fft);
    int n;
    n = $clog2(size_fft);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fft_cooley_tukey_helpers_stage_sequencer_sat_counter.sv
// fft_cooley_tukey_helpers_SatCounter: clear/enable up-counter that sticks at all-ones
module fft_cooley_tukey_helpers_SatCounter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins over enable; increment stops once every bit is set
  always_comb cnt_d = clr_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/fft_cooley_tukey_helpers_stage_sequencer.sv
// fft_cooley_tukey_helpers_stage_sequencer: per-frame stage sequencing FSM; FFT_SEQUENCER_PERF_EN adds a frame latency counter
module fft_cooley_tukey_helpers_stage_sequencer
  import fft_cooley_tukey_helpers_SequencerPkg::*;
#(
  parameter int SIZE_FFT = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               recv_val,
  output logic                               recv_rdy,
  output logic                               load_en,
  output logic [stage_width(SIZE_FFT)-1:0]   stage,
  output logic                               bfly_val,
  input  logic                               bfly_rdy,
  input  logic                               bfly_done,
  output logic                               wb_en,
  output logic                               send_val,
  input  logic                               send_rdy,
  output logic                               busy
`ifdef FFT_SEQUENCER_PERF_EN
  ,
  output logic [PERF_W-1:0]                  perf_cycles
`endif
);
  localparam int N_STAGES = $clog2(SIZE_FFT);
  localparam int STAGE_W = stage_width(SIZE_FFT);
  localparam logic [STAGE_W-1:0] LAST = STAGE_W'(N_STAGES - 1);
  seq_state_t state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  // next state, stage advance and handshake strobes
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    recv_rdy = state_q == IDLE;
    bfly_val = state_q == ISSUE;
    send_val = state_q == DONE;
    busy     = state_q != IDLE;
    load_en  = 1'b0;
    wb_en    = 1'b0;
    case (state_q)
      IDLE: if (recv_val) begin
        load_en = 1'b1;
        stage_d = '0;
        state_d = ISSUE;
      end
      ISSUE: if (bfly_rdy) state_d = WAIT;
      WAIT: if (bfly_done) begin
        wb_en   = 1'b1;
        state_d = (stage_q == LAST) ? DONE : ISSUE;
        stage_d = (stage_q == LAST) ? stage_q : stage_q + 1'b1;
      end
      DONE: if (send_rdy) begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end
  assign stage = stage_q;
`ifdef FFT_SEQUENCER_PERF_EN
  logic send_hs;
  logic [PERF_W-1:0] cnt, perf_q, perf_d;
  assign send_hs = send_val & send_rdy;
  // counter idles at zero, counts accept through the cycle before handshake, clears on handshake
  fft_cooley_tukey_helpers_SatCounter #(.W(PERF_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (send_hs),
    .en_i  (load_en | busy),
    .cnt_o (cnt)
  );
  // the handshake cycle itself is added here so the capture is inclusive of both ends
  always_comb perf_d = send_hs ? ((&cnt) ? cnt : cnt + 1'b1) : perf_q;
  // captured latency of the last completed frame
  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_fft_cooley_tukey_helpers_stage_sequencer.sv
// tb_fft_cooley_tukey_helpers_stage_sequencer: directed checks of the stage sequencer at SIZE_FFT=8 and SIZE_FFT=2
module tb_fft_cooley_tukey_helpers_stage_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic recv_val = 1'b0, bfly_rdy = 1'b0, bfly_done = 1'b0, send_rdy = 1'b0;
  logic recv_rdy, load_en, bfly_val, wb_en, send_val, busy;
  logic recv_rdy2, load_en2, bfly_val2, wb_en2, send_val2, busy2;
  logic [1:0] stage;
  logic [0:0] stage2;
  logic [5:0] o, o2;
`ifdef FFT_SEQUENCER_PERF_EN
  logic [15:0] perf, perf2;
`endif
  int total = 0, bad = 0;
  // table rows: {recv_val,bfly_rdy,bfly_done,send_rdy}_{recv_rdy,load_en,bfly_val,wb_en,send_val,busy}_{stage}
  localparam logic [11:0] NOM [9] = '{
    12'b1000_110000_00, 12'b0100_001001_00, 12'b0010_000101_00,
    12'b0100_001001_01, 12'b0010_000101_01, 12'b0100_001001_10,
    12'b0010_000101_10, 12'b0001_000011_10, 12'b0000_100000_00};
  localparam logic [11:0] BP [16] = '{
    12'b1000_110000_00, 12'b0100_001001_00, 12'b0010_000101_00,
    12'b0000_001001_01, 12'b0000_001001_01, 12'b0000_001001_01, 12'b0000_001001_01,
    12'b0100_001001_01, 12'b0010_000101_01, 12'b0100_001001_10, 12'b0010_000101_10,
    12'b0000_000011_10, 12'b0000_000011_10, 12'b0000_000011_10,
    12'b0001_000011_10, 12'b0000_100000_00};
  localparam logic [11:0] SPUR [10] = '{
    12'b0010_100000_00, 12'b0000_100000_00, 12'b1000_110000_00,
    12'b0010_001001_00, 12'b0000_001001_00, 12'b0110_001001_00,
    12'b1000_000001_00, 12'b0000_000001_00, 12'b0010_000101_00,
    12'b0000_001001_01};
  localparam logic [11:0] MID [5] = '{
    12'b1000_110000_00, 12'b0100_001001_00, 12'b0010_000101_00,
    12'b0100_001001_01, 12'b0000_000001_01};
  localparam logic [11:0] SZ2 [5] = '{
    12'b1000_110000_00, 12'b0100_001001_00, 12'b0010_000101_00,
    12'b0001_000011_00, 12'b0000_100000_00};

  fft_cooley_tukey_helpers_stage_sequencer #(.SIZE_FFT(8)) dut (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy), .load_en(load_en),
    .stage(stage), .bfly_val(bfly_val), .bfly_rdy(bfly_rdy), .bfly_done(bfly_done),
    .wb_en(wb_en), .send_val(send_val), .send_rdy(send_rdy), .busy(busy)
`ifdef FFT_SEQUENCER_PERF_EN
    , .perf_cycles(perf)
`endif
  );

  fft_cooley_tukey_helpers_stage_sequencer #(.SIZE_FFT(2)) dut2 (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy2), .load_en(load_en2),
    .stage(stage2), .bfly_val(bfly_val2), .bfly_rdy(bfly_rdy), .bfly_done(bfly_done),
    .wb_en(wb_en2), .send_val(send_val2), .send_rdy(send_rdy), .busy(busy2)
`ifdef FFT_SEQUENCER_PERF_EN
    , .perf_cycles(perf2)
`endif
  );

  assign o  = {recv_rdy, load_en, bfly_val, wb_en, send_val, busy};
  assign o2 = {recv_rdy2, load_en2, bfly_val2, wb_en2, send_val2, busy2};

  always #5 clk = ~clk;

  task automatic cyc(input logic rv, input logic rdy, input logic dn, input logic srdy);
    @(posedge clk);
    #1;
    recv_val = rv; bfly_rdy = rdy; bfly_done = dn; send_rdy = srdy;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc(0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cyc(0, 0, 0, 0);
    total++;
    if ({o, stage} !== {6'b100000, 2'd0}) begin
      bad++; $display("FAIL reset_hold got=%b/%0d exp=100000/0", o, stage);
    end
    total++;
    if ({o2, stage2} !== {6'b100000, 1'b0}) begin
      bad++; $display("FAIL reset_hold_sz2 got=%b/%0d exp=100000/0", o2, stage2);
    end
`ifdef FFT_SEQUENCER_PERF_EN
    total++;
    if (perf !== 16'd0) begin
      bad++; $display("FAIL reset_perf got=%0d exp=0", perf);
    end
`endif
    reset = 1'b0;
    cyc(0, 0, 0, 0);
    total++;
    if ({o, stage} !== {6'b100000, 2'd0}) begin
      bad++; $display("FAIL reset_idle got=%b/%0d exp=100000/0", o, stage);
    end
  endtask

  task automatic test_nominal();
    logic [11:0] t;
    int wb = 0;
    for (int c = 0; c < 9; c++) begin
      t = NOM[c];
      cyc(t[11], t[10], t[9], t[8]);
      wb += int'(wb_en);
      total++;
      if ({o, stage} !== t[7:0]) begin
        bad++; $display("FAIL nominal c=%0d got=%b/%0d exp=%b/%0d", c, o, stage, t[7:2], t[1:0]);
      end
    end
    total++;
    if (wb != 3) begin
      bad++; $display("FAIL nominal_wb_count got=%0d exp=3", wb);
    end
`ifdef FFT_SEQUENCER_PERF_EN
    total++;
    if (perf !== 16'd8) begin
      bad++; $display("FAIL nominal_perf got=%0d exp=8", perf);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [11:0] t;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      t = BP[c];
      cyc(t[11], t[10], t[9], t[8]);
      total++;
      if ({o, stage} !== t[7:0]) begin
        bad++; $display("FAIL backpressure c=%0d got=%b/%0d exp=%b/%0d", c, o, stage, t[7:2], t[1:0]);
      end
    end
`ifdef FFT_SEQUENCER_PERF_EN
    total++;
    if (perf !== 16'd15) begin
      bad++; $display("FAIL backpressure_perf got=%0d exp=15", perf);
    end
`endif
  endtask

  task automatic test_spurious();
    logic [11:0] t;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      t = SPUR[c];
      cyc(t[11], t[10], t[9], t[8]);
      total++;
      if ({o, stage} !== t[7:0]) begin
        bad++; $display("FAIL spurious c=%0d got=%b/%0d exp=%b/%0d", c, o, stage, t[7:2], t[1:0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] t;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      t = MID[c];
      cyc(t[11], t[10], t[9], t[8]);
      total++;
      if ({o, stage} !== t[7:0]) begin
        bad++; $display("FAIL midreset_pre c=%0d got=%b/%0d exp=%b/%0d", c, o, stage, t[7:2], t[1:0]);
      end
    end
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    total++;
    if ({o, stage} !== {6'b100000, 2'd0}) begin
      bad++; $display("FAIL midreset_idle got=%b/%0d exp=100000/0", o, stage);
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(0, 1, 1, 1);
      total++;
      if ({send_val, busy} !== 2'b00) begin
        bad++; $display("FAIL midreset_no_send c=%0d got send_val=%b busy=%b exp 0 0", c, send_val, busy);
      end
    end
    test_nominal();
  endtask

  task automatic test_size2();
    logic [11:0] t;
    int wb = 0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      t = SZ2[c];
      cyc(t[11], t[10], t[9], t[8]);
      wb += int'(wb_en2);
      total++;
      if ({o2, stage2} !== {t[7:2], t[0]}) begin
        bad++; $display("FAIL size2 c=%0d got=%b/%0d exp=%b/%0d", c, o2, stage2, t[7:2], t[0]);
      end
    end
    total++;
    if (wb != 1) begin
      bad++; $display("FAIL size2_wb_count got=%0d exp=1", wb);
    end
`ifdef FFT_SEQUENCER_PERF_EN
    total++;
    if (perf2 !== 16'd4) begin
      bad++; $display("FAIL size2_perf got=%0d exp=4", perf2);
    end
`endif
  endtask

`ifdef FFT_SEQUENCER_PERF_EN
  task automatic test_saturation();
    do_reset();
    cyc(1, 0, 0, 0);
    repeat (70000) cyc(0, 0, 0, 0);
    repeat (3) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
    end
    cyc(0, 0, 0, 1);
    total++;
    if (send_val !== 1'b1) begin
      bad++; $display("FAIL sat_send_val got=%b exp=1", send_val);
    end
    cyc(0, 0, 0, 0);
    total++;
    if (perf !== 16'hFFFF) begin
      bad++; $display("FAIL sat_perf got=%h exp=ffff", perf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_spurious();
    test_reset_mid_frame();
    test_size2();
`ifdef FFT_SEQUENCER_PERF_EN
    test_saturation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
